// File: rtl/keymatrix_scan.sv
// keymatrix_scan: keyboard matrix front-end for the console I/O path.
// Double-flop synchronises the raw matrix plus the alpha-lock switch, debounces
// every key on a shared prescaler tick, serves the CPU column-select/row-read
// scan from the debounced state, and reports press/release changes through a
// small show-ahead event FIFO.
//
// Ports:
//   clk, reset_n          system clock, async active-low reset
//   col_sel, alpha_sel    CPU scan select (alpha_sel overrides col_sel)
//   key_raw, alpha_raw    asynchronous raw key-down inputs
//   row_n                 registered active-low row readback
//   evt_valid/evt_ready   event FIFO head handshake
//   evt_key, evt_press    head event: key index, 1 = press / 0 = release

// Per-key debounce cell: deb follows sync_in only after DEBOUNCE_TICKS
// consecutive ticks of disagreement.
module keymatrix_deb_cell #(
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic sync_in,
  output logic deb
);
  localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (tick) begin
      if (sync_in == deb) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_TICKS - 1)) begin
        deb <= sync_in;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module keymatrix_scan #(
  parameter int NCOLS          = 8,
  parameter int NROWS          = 8,
  parameter int ALPHA_ROW      = 4,
  parameter int TICK_DIV       = 1024,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int FIFO_DEPTH     = 8,
  localparam int NKEYS = NCOLS * NROWS + 1,
  localparam int KW    = $clog2(NKEYS),
  localparam int CW    = $clog2(NCOLS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [CW-1:0]          col_sel,
  input  logic                   alpha_sel,
  input  logic [NCOLS*NROWS-1:0] key_raw,
  input  logic                   alpha_raw,
  output logic [NROWS-1:0]       row_n,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [KW-1:0]          evt_key,
  output logic                   evt_press
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [KW-1:0] key;
    logic          press;
  } evt_t;

  // ---- synchroniser (alpha-lock rides as the top key index)
  logic [NKEYS-1:0] sync1, sync2, deb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {alpha_raw, key_raw};
      sync2 <= sync1;
    end
  end

  // ---- debounce prescaler
  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pcnt <= '0;
    else          pcnt <= tick ? '0 : pcnt + 1'b1;
  end

  keymatrix_deb_cell #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb [NKEYS-1:0] (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .sync_in (sync2),
    .deb     (deb)
  );

  // ---- CPU readback
  logic [KW-1:0]    col_base;
  logic [NROWS-1:0] row_nxt;

  assign col_base = KW'(int'(col_sel) * NROWS);

  always_comb begin
    row_nxt = '1;
    if (alpha_sel)                   row_nxt[ALPHA_ROW] = ~deb[NKEYS-1];
    else if (int'(col_sel) < NCOLS)  row_nxt = ~NROWS'(deb >> col_base);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) row_n <= '1;
    else          row_n <= row_nxt;
  end

  // ---- event scanner + FIFO
  logic [KW-1:0]    p;
  logic [NKEYS-1:0] reported;
  logic [AW:0]      wptr, rptr;
  evt_t [FIFO_DEPTH-1:0] mem;
  logic             full, empty, push, pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // A key blocked by a full FIFO keeps its reported bit, so it is simply
  // picked up again on a later lap of the pointer.
  assign push  = (deb[p] != reported[p]) && !full;
  assign pop   = !empty && evt_ready;

  assign evt_valid = !empty;
  assign evt_key   = mem[rptr[AW-1:0]].key;
  assign evt_press = mem[rptr[AW-1:0]].press;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p        <= '0;
      reported <= '0;
      wptr     <= '0;
      rptr     <= '0;
      mem      <= '0;
    end else begin
      p <= (p == KW'(NKEYS - 1)) ? '0 : p + 1'b1;
      if (push) begin
        mem[wptr[AW-1:0]] <= '{key: p, press: deb[p]};
        wptr              <= wptr + 1'b1;
        reported[p]       <= deb[p];
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_keymatrix_scan.sv
module tb_keymatrix_scan;
  localparam int NCOLS = 8, NROWS = 8, ALPHA_ROW = 4;
  localparam int TICK_DIV = 4, DEB = 3, FD = 2;
  localparam int NKEYS = NCOLS * NROWS + 1;
  localparam int KW = $clog2(NKEYS), CW = $clog2(NCOLS);

  logic                   clk = 1'b0, reset_n = 1'b0;
  logic [CW-1:0]          col_sel = '0;
  logic                   alpha_sel = 1'b0, alpha_raw = 1'b0;
  logic [NCOLS*NROWS-1:0] key_raw = '0;
  logic [NROWS-1:0]       row_n;
  logic                   evt_valid, evt_ready = 1'b0, evt_press;
  logic [KW-1:0]          evt_key;

  int checks = 0, errors = 0;

  typedef struct { int key; bit press; } ev_t;
  ev_t evq[$];

  typedef struct { logic [CW-1:0] col; logic asel; logic [NROWS-1:0] exp; } rb_vec_t;
  rb_vec_t tbl[6];

  bit mstate[NKEYS];   // reference: net debounced state per key
  int evcnt[NKEYS];
  bit evlast[NKEYS];
  int pm;              // scan pointer position (resets to 0, +1 per cycle, wraps)

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) pm <= 0;
    else          pm <= (pm == NKEYS - 1) ? 0 : pm + 1;

  keymatrix_scan #(
    .NCOLS(NCOLS), .NROWS(NROWS), .ALPHA_ROW(ALPHA_ROW), .TICK_DIV(TICK_DIV),
    .DEBOUNCE_TICKS(DEB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .col_sel(col_sel), .alpha_sel(alpha_sel),
    .key_raw(key_raw), .alpha_raw(alpha_raw), .row_n(row_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key), .evt_press(evt_press)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // rmode: 0 = never ready, 1 = always ready, 2 = random ready
  task automatic run(input int n, input int rmode);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      evt_ready = (rmode == 1) ? 1'b1 : (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (evt_valid && evt_ready) begin
        e.key = int'(evt_key);
        e.press = evt_press;
        evq.push_back(e);
      end
    end
    @(posedge clk);
    #1 evt_ready = 1'b0;
  endtask

  task automatic tally();
    for (int k = 0; k < NKEYS; k++) begin evcnt[k] = 0; evlast[k] = 0; end
    foreach (evq[i]) begin
      evcnt[evq[i].key]++;
      evlast[evq[i].key] = evq[i].press;
    end
  endtask

  task automatic set_key(input int k, input bit v);
    if (k == NKEYS - 1) alpha_raw = v;
    else                key_raw[k] = v;
  endtask

  initial begin
    int lat, bad, guard, nflip;
    int flipped[$];
    logic [NROWS-1:0] exp_row;

    // ---------------- reset with random inputs
    for (int i = 0; i < 20; i++) begin
      key_raw = {$urandom, $urandom};
      alpha_raw = 1'($urandom);
      col_sel = CW'($urandom);
      alpha_sel = 1'($urandom);
      @(negedge clk);
      check("reset_row_n", row_n, 8'hFF);
      check("reset_evt_valid", evt_valid, 0);
    end
    check("reset_evt_key", evt_key, 0);
    check("reset_evt_press", evt_press, 0);
    key_raw = '0; alpha_raw = 0; col_sel = '0; alpha_sel = 0;
    @(negedge clk);
    reset_n = 1'b1;
    evq.delete();
    run(10 * NKEYS, 1);
    check("idle_no_events", evq.size(), 0);

    // ---------------- debounce latency, key 10 = column 1 row 2
    col_sel = 3'd1;
    @(posedge clk);
    #1 key_raw[10] = 1'b1;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1 if (lat < 0 && row_n[2] == 1'b0) lat = n;
    end
    check("deb_latency_seen", lat > 0, 1);
    check("deb_latency_not_early", lat >= 12, 1);
    check("deb_latency_not_late", lat <= 15, 1);
    check("deb_row_n", row_n, 8'hFB);
    evq.delete();
    run(NKEYS + 10, 1);
    check("press10_count", evq.size(), 1);
    if (evq.size() > 0) begin
      check("press10_key", evq[0].key, 10);
      check("press10_press", evq[0].press, 1);
    end
    evq.delete();
    key_raw[10] = 1'b0;
    run(NKEYS + 30, 1);
    check("release10_count", evq.size(), 1);
    if (evq.size() > 0) begin
      check("release10_key", evq[0].key, 10);
      check("release10_press", evq[0].press, 0);
    end

    // ---------------- bounce: 5-cycle pulses never reach three agreeing ticks
    evq.delete();
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      key_raw[10] = ((i / 5) % 2) == 0;
      if (row_n[2] == 1'b0) bad++;
      if (evt_valid) bad++;
    end
    key_raw[10] = 1'b0;
    run(200, 1);
    check("bounce_no_deb_or_evt", bad, 0);
    check("bounce_no_events", evq.size(), 0);
    check("bounce_row_n", row_n, 8'hFF);

    // ---------------- alpha-lock
    alpha_raw = 1'b1;
    alpha_sel = 1'b1;
    run(NKEYS + 30, 1);
    check("alpha_row_n", row_n, 8'hEF);
    check("alpha_evt_count", evq.size(), 1);
    if (evq.size() > 0) begin
      check("alpha_evt_key", evq[0].key, 64);
      check("alpha_evt_press", evq[0].press, 1);
    end
    alpha_sel = 1'b0;
    col_sel = '0;
    @(negedge clk);
    @(negedge clk);
    check("alpha_off_col0", row_n, 8'hFF);
    evq.delete();
    alpha_raw = 1'b0;
    run(NKEYS + 30, 1);
    tally();
    check("alpha_release", evcnt[64] == 1 && evlast[64] == 0 && evq.size() == 1, 1);

    // ---------------- readback table with keys 0, 10, 63 and alpha held
    tbl[0] = '{3'd0, 1'b0, 8'hFE};
    tbl[1] = '{3'd1, 1'b0, 8'hFB};
    tbl[2] = '{3'd7, 1'b0, 8'h7F};
    tbl[3] = '{3'd3, 1'b0, 8'hFF};
    tbl[4] = '{3'd5, 1'b1, 8'hEF};
    tbl[5] = '{3'd0, 1'b1, 8'hEF};
    evq.delete();
    key_raw[0] = 1; key_raw[10] = 1; key_raw[63] = 1; alpha_raw = 1;
    run(NKEYS + 40, 1);
    check("table_press_events", evq.size(), 4);
    foreach (tbl[i]) begin
      @(negedge clk);
      col_sel = tbl[i].col;
      alpha_sel = tbl[i].asel;
      @(posedge clk);
      #1 check($sformatf("table_row_n[%0d]", i), row_n, tbl[i].exp);
    end
    alpha_sel = 1'b0;
    evq.delete();
    key_raw = '0; alpha_raw = 0;
    run(3 * NKEYS, 2);
    tally();
    check("table_release_events",
          evq.size() == 4 && evcnt[0] == 1 && evcnt[10] == 1 && evcnt[63] == 1 && evcnt[64] == 1 &&
          !evlast[0] && !evlast[10] && !evlast[63] && !evlast[64], 1);

    // ---------------- reset mid-operation
    key_raw[5] = 1; key_raw[12] = 1;
    run(NKEYS + 30, 0);
    check("midrst_fifo_loaded", evt_valid, 1);
    key_raw[12] = 0;
    run(3, 0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_evt_valid", evt_valid, 0);
    check("midrst_row_n", row_n, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    evq.delete();
    run(NKEYS + 40, 1);
    check("midrst_held_press", evq.size() == 1 && evq[0].key == 5 && evq[0].press == 1, 1);
    evq.delete();
    key_raw[5] = 0;
    run(NKEYS + 40, 1);
    check("midrst_release5", evq.size() == 1 && evq[0].key == 5 && evq[0].press == 0, 1);

    // ---------------- FIFO full (depth 2), order 3, 7, 20
    key_raw[3] = 1;
    run(NKEYS + 30, 0);
    check("full_head3_valid", evt_valid, 1);
    check("full_head3_key", evt_key, 3);
    key_raw[7] = 1;
    run(NKEYS + 30, 0);
    key_raw[20] = 1;
    run(2 * NKEYS, 0);
    check("full_valid_held", evt_valid, 1);
    check("full_head_stable_key", evt_key, 3);
    check("full_head_stable_press", evt_press, 1);
    // pop exactly while the scanner visits key 20 with the FIFO full
    guard = 0;
    do begin @(negedge clk); guard++; end while (pm != 20 && guard < 200);
    check("full_align_pm", pm, 20);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    check("full_second_key", evt_key, 7);
    run(10, 0);
    @(negedge clk);
    evt_ready = 1'b1;
    check("full_pop7_key", evt_key, 7);
    @(negedge clk);
    evt_ready = 1'b0;
    check("full_push_was_blocked", evt_valid, 0);
    evq.delete();
    run(NKEYS + 5, 1);
    check("full_retry20", evq.size() == 1 && evq[0].key == 20 && evq[0].press == 1, 1);
    run(5, 1);
    check("full_drained", evt_valid, 0);
    evq.delete();
    key_raw[3] = 0; key_raw[7] = 0; key_raw[20] = 0;
    run(3 * NKEYS, 2);
    tally();
    check("full_release_once",
          evq.size() == 3 && evcnt[3] == 1 && evcnt[7] == 1 && evcnt[20] == 1 &&
          !evlast[3] && !evlast[7] && !evlast[20], 1);

    // ---------------- randomized rounds against the net-state model
    for (int k = 0; k < NKEYS; k++) mstate[k] = 0;
    for (int rnd = 0; rnd < 10; rnd++) begin
      flipped.delete();
      nflip = $urandom_range(1, 4);
      while (flipped.size() < nflip) begin
        int k;
        k = $urandom_range(0, NKEYS - 1);
        if (!(k inside {flipped})) flipped.push_back(k);
      end
      @(negedge clk);
      foreach (flipped[i]) begin
        mstate[flipped[i]] = !mstate[flipped[i]];
        set_key(flipped[i], mstate[flipped[i]]);
      end
      evq.delete();
      run(600, 2);
      tally();
      check($sformatf("rand%0d_evt_total", rnd), evq.size(), nflip);
      bad = 0;
      foreach (flipped[i])
        if (evcnt[flipped[i]] != 1 || evlast[flipped[i]] != mstate[flipped[i]]) bad++;
      check($sformatf("rand%0d_evt_keys", rnd), bad, 0);
      for (int c = 0; c < NCOLS; c++) begin
        @(negedge clk);
        col_sel = CW'(c);
        alpha_sel = 1'b0;
        for (int r = 0; r < NROWS; r++) exp_row[r] = !mstate[c * NROWS + r];
        @(posedge clk);
        #1 check($sformatf("rand%0d_row_n_col%0d", rnd, c), row_n, exp_row);
      end
      @(negedge clk);
      alpha_sel = 1'b1;
      exp_row = '1;
      exp_row[ALPHA_ROW] = !mstate[NKEYS - 1];
      @(posedge clk);
      #1 check($sformatf("rand%0d_row_n_alpha", rnd), row_n, exp_row);
      alpha_sel = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
